axi_rdata_fifo: RTL
===================

AXI_RDATA_FIFO -- requirements
Module: axi_rdata_fifo

Interface
REQ-001 SHALL provide parameter ENTRY_NUM, default 8, meaning the number of FIFO entries; the one-hot pointer width equals ENTRY_NUM.
REQ-002 SHALL provide parameter DATA_WIDTH, default 128, meaning the R-channel data width.
REQ-003 SHALL provide the following ports:
- cpu_clk  in  1  single clock; all state changes on rising edge.
- cpu_rst_b  in  1  asynchronous active-low reset.
- pad_biu_rvalid  in  1  read-data beat valid from the slave side.
- pad_biu_rdata  in  DATA_WIDTH  read data.
- pad_biu_rid  in  8  read ID.
- pad_biu_rresp  in  2  read response.
- pad_biu_rlast  in  1  last beat of burst.
- fifo_pad_rready  out  1  FIFO can accept a beat.
- fifo_biu_rvalid  out  1  delayed beat valid toward the BIU.
- fifo_biu_rdata  out  DATA_WIDTH  delayed data.
- fifo_biu_rid  out  8  delayed ID.
- fifo_biu_rresp  out  2  delayed response.
- fifo_biu_rlast  out  1  delayed last.
- biu_pad_rready  in  1  BIU accepts the beat.
- delay_num  in  32  per-beat hold latency, sampled at push.
- fifo_entry_cnt  out  4  number of valid entries (0..8).

Function
REQ-004 SHALL hold create_ptr and pop_ptr as ENTRY_NUM-bit one-hot registers; each SHALL reset to bit0 and rotate left by one position on push and on pop respectively, wrapping from bit7 to bit0.
REQ-005 SHALL keep an entry_vld bit per entry.
REQ-006 fifo_pad_rready SHALL equal NOT(OR(create_ptr AND entry_vld)), i.e. the FIFO is not full.
REQ-007 A push SHALL occur when pad_biu_rvalid and fifo_pad_rready are both 1.
REQ-008 On a push, the entry at create_ptr SHALL capture {rdata, rid, rresp, rlast}, SHALL set its entry_vld bit, and SHALL load its 32-bit counter with delay_num.
REQ-009 Each valid entry counter SHALL decrement by 1 per cycle while nonzero and SHALL saturate at 0.
REQ-010 An entry SHALL be done when it is valid and its counter is 0.
REQ-011 fifo_biu_rvalid SHALL equal entry_vld[head] AND done[head], where head is selected by pop_ptr.
REQ-012 The minimum push-to-rvalid latency SHALL be delay_num+1 cycles.
REQ-013 A pop SHALL occur when fifo_biu_rvalid and biu_pad_rready are both 1; it SHALL clear entry_vld[head] and advance pop_ptr.
REQ-014 fifo_biu_rdata, rid, rresp and rlast SHALL be the one-hot AND-OR mux of the head entry, gated to all-zero while fifo_biu_rvalid is 0.
REQ-015 Once fifo_biu_rvalid is asserted, it and all fifo_biu_* payload outputs SHALL remain stable until the pop.
REQ-016 Beats SHALL leave in push order. A later entry whose counter has expired SHALL NOT bypass an earlier, unexpired head.
REQ-017 On a simultaneous push and pop in the same cycle, both SHALL take effect and fifo_entry_cnt SHALL be unchanged.
REQ-018 When the FIFO is full, fifo_pad_rready SHALL be 0 even if a pop occurs in the same cycle; there is no full-bypass.
REQ-019 When the FIFO is empty, fifo_biu_rvalid SHALL be 0; there is no empty-bypass, so a pushed beat never appears in its push cycle.
REQ-020 fifo_entry_cnt SHALL increment on push-only, decrement on pop-only, and hold otherwise.
REQ-021 fifo_entry_cnt SHALL equal the popcount of entry_vld at all times.
REQ-022 delay_num SHALL be sampled only at push; later changes to it SHALL NOT affect stored entries.
REQ-023 A delay_num of 0xFFFFFFFF SHALL be legal, with no counter overflow.

Reset
REQ-024 While cpu_rst_b is 0, the block SHALL force the following state asynchronously:
- entry_vld = 0, create_ptr = pop_ptr = 8'h01, all counters = 0, all stored payloads = 0.
- fifo_biu_rvalid = 0 and all fifo_biu_* payload outputs = 0.
- fifo_entry_cnt = 0.
- fifo_pad_rready = 1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight beats without emitting them.
REQ-026 After release, the first push SHALL go to entry 0.

Verification
REQ-027 The bench SHALL cover the following scenarios:
- Single beat: delay_num=3, push rdata=0xA5, rid=0x12, rlast=1, biu_pad_rready=1 -> rvalid rises exactly 4 cycles after the push, pops the next edge, fifo_entry_cnt returns to 0.
- Fill: 8 pushes with delay_num=100, biu_pad_rready=0 -> fifo_pad_rready=0 after the 8th push and fifo_entry_cnt=8; a 9th rvalid is not accepted.
- Order/no-bypass: push A with delay 20, then B with delay 0 -> B is not output until A pops; output order is A, B.
- Wrap-around: 20 beats back-to-back, delay 0, rready=1 -> all 20 emerge in order with matching ID/data; pointers wrap twice with no loss.
- Backpressure stability: rvalid high, rready held 0 for 5 cycles -> payload unchanged and rvalid held; pops on the first rready=1 cycle.
- Reset mid-flight: 3 entries valid, assert cpu_rst_b=0 for 1 cycle -> rvalid=0, fifo_entry_cnt=0, rready=1 immediately; the next push lands in entry 0.

Source files
------------

// File: rtl/axi_rdata_fifo.sv
// Delay FIFO for the AXI R channel. Each beat is held for a latency sampled at
// push, then released strictly in push order toward the BIU.

module axi_rdata_fifo_entry #(
    parameter int DATA_WIDTH = 128,
    parameter int PW         = DATA_WIDTH + 11
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_b,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   delay_num,
    input  logic [PW-1:0] payload_in,
    output logic          vld,
    output logic          done,
    output logic [PW-1:0] payload
);
    logic [31:0] cnt;

    // A push only targets an invalid entry and a pop only a valid one, so the
    // two never hit the same entry in one cycle.
    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            vld     <= 1'b0;
            cnt     <= 32'd0;
            payload <= '0;
        end else if (push) begin
            vld     <= 1'b1;
            cnt     <= delay_num;
            payload <= payload_in;
        end else begin
            if (pop)
                vld <= 1'b0;
            if (vld && (cnt != 32'd0))
                cnt <= cnt - 32'd1;
        end
    end

    assign done = vld && (cnt == 32'd0);
endmodule

module axi_rdata_fifo #(
    parameter int ENTRY_NUM  = 8,
    parameter int DATA_WIDTH = 128
) (
    input  logic                            cpu_clk,
    input  logic                            cpu_rst_b,
    input  logic                            pad_biu_rvalid,
    input  logic [DATA_WIDTH-1:0]           pad_biu_rdata,
    input  logic [7:0]                      pad_biu_rid,
    input  logic [1:0]                      pad_biu_rresp,
    input  logic                            pad_biu_rlast,
    output logic                            fifo_pad_rready,
    output logic                            fifo_biu_rvalid,
    output logic [DATA_WIDTH-1:0]           fifo_biu_rdata,
    output logic [7:0]                      fifo_biu_rid,
    output logic [1:0]                      fifo_biu_rresp,
    output logic                            fifo_biu_rlast,
    input  logic                            biu_pad_rready,
    input  logic [31:0]                     delay_num,
    output logic [$clog2(ENTRY_NUM+1)-1:0]  fifo_entry_cnt
);
    localparam int PW    = DATA_WIDTH + 11;
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);

    logic [ENTRY_NUM-1:0]         create_ptr;
    logic [ENTRY_NUM-1:0]         pop_ptr;
    logic [ENTRY_NUM-1:0]         entry_vld;
    logic [ENTRY_NUM-1:0]         entry_done;
    logic [ENTRY_NUM-1:0][PW-1:0] entry_payload;
    logic [PW-1:0]                payload_in;
    logic [PW-1:0]                head_payload;
    logic [CNT_W-1:0]             cnt_q;
    logic                         push;
    logic                         pop;

    assign payload_in = {pad_biu_rdata, pad_biu_rid, pad_biu_rresp, pad_biu_rlast};

    // Full exactly when the slot the writer points at is still occupied.
    assign fifo_pad_rready = ~|(create_ptr & entry_vld);
    assign push            = pad_biu_rvalid & fifo_pad_rready;
    // entry_done already includes the valid bit.
    assign fifo_biu_rvalid = |(pop_ptr & entry_done);
    assign pop             = fifo_biu_rvalid & biu_pad_rready;

    genvar g;
    generate
        for (g = 0; g < ENTRY_NUM; g++) begin : g_entry
            axi_rdata_fifo_entry #(
                .DATA_WIDTH (DATA_WIDTH),
                .PW         (PW)
            ) u_entry (
                .cpu_clk    (cpu_clk),
                .cpu_rst_b  (cpu_rst_b),
                .push       (push & create_ptr[g]),
                .pop        (pop & pop_ptr[g]),
                .delay_num  (delay_num),
                .payload_in (payload_in),
                .vld        (entry_vld[g]),
                .done       (entry_done[g]),
                .payload    (entry_payload[g])
            );
        end
    endgenerate

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            create_ptr <= {{(ENTRY_NUM-1){1'b0}}, 1'b1};
            pop_ptr    <= {{(ENTRY_NUM-1){1'b0}}, 1'b1};
        end else begin
            if (push)
                create_ptr <= {create_ptr[ENTRY_NUM-2:0], create_ptr[ENTRY_NUM-1]};
            if (pop)
                pop_ptr <= {pop_ptr[ENTRY_NUM-2:0], pop_ptr[ENTRY_NUM-1]};
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b)
            cnt_q <= '0;
        else if (push && !pop)
            cnt_q <= cnt_q + 1'b1;
        else if (pop && !push)
            cnt_q <= cnt_q - 1'b1;
    end

    assign fifo_entry_cnt = cnt_q;

    // One-hot AND-OR select of the head, forced to zero while nothing is offered.
    always_comb begin
        head_payload = '0;
        for (int i = 0; i < ENTRY_NUM; i++)
            head_payload = head_payload | (entry_payload[i] & {PW{pop_ptr[i]}});
        head_payload = head_payload & {PW{fifo_biu_rvalid}};
    end

    assign {fifo_biu_rdata, fifo_biu_rid, fifo_biu_rresp, fifo_biu_rlast} = head_payload;
endmodule
